segasys1_vtiming: RTL and testbench

- Raster timing generator and pixel output stage for the SEGA System 1/2 core; sits on both sides of the core top.
- Upstream role: counts the pixel position PH/PV on each core pixel-clock enable and feeds it to the core.
- Downstream role: captures the core's 12-bit pixel, aligns sync and blanking to the core's pixel latency, and drives blanked RGB plus syncs to the framework video path.

---
 rtl/segasys1_vtiming.sv | 102 ++++++++++
 tb/tb_segasys1_vtiming.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/segasys1_vtiming.sv
// Raster timing generator and pixel output stage for the SEGA System 1/2 core:
// PH/PV counters feed the core, and blanking/sync are delayed to line up with its pixel.
module segasys1_vtiming #(
  parameter int H_TOTAL  = 320,
  parameter int H_VIS    = 256,
  parameter int HS_START = 280,
  parameter int HS_WIDTH = 24,
  parameter int V_TOTAL  = 262,
  parameter int V_VIS    = 224,
  parameter int VS_START = 240,
  parameter int VS_WIDTH = 3,
  parameter int PIX_LAT  = 2
) (
  input  logic        clk40M,
  input  logic        reset,
  input  logic        PCLK_EN,
  input  logic [11:0] POUT,
  output logic [8:0]  PH,
  output logic [8:0]  PV,
  output logic        CE_PIX,
  output logic [3:0]  R,
  output logic [3:0]  G,
  output logic [3:0]  B,
  output logic        HBLANK,
  output logic        VBLANK,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        FRAME
);

  localparam int W = 4 * PIX_LAT;

  localparam logic [9:0] PH_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] PV_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] HB_START = 10'(H_VIS);
  localparam logic [9:0] VB_START = 10'(V_VIS);
  localparam logic [9:0] HS_FIRST = 10'(HS_START);
  localparam logic [9:0] HS_END   = 10'(HS_START + HS_WIDTH);
  localparam logic [9:0] VS_FIRST = 10'(VS_START);
  localparam logic [9:0] VS_END   = 10'(VS_START + VS_WIDTH);

  logic [9:0]   ph_ext;
  logic [9:0]   pv_ext;
  logic         ph_wrap;
  logic         pv_wrap;
  logic [3:0]   tmg_p0;
  logic [W-1:0] tmg_pn;
  logic [W-1:0] tmg_shift;
  logic [3:0]   tmg_next;

  // Stage 0: raw timing decoded from the count currently presented, packed {vs,hs,vb,hb}
  always_comb begin
    ph_ext  = {1'b0, PH};
    pv_ext  = {1'b0, PV};
    ph_wrap = (ph_ext == PH_LAST);
    pv_wrap = (pv_ext == PV_LAST);
    tmg_p0  = {(pv_ext >= VS_FIRST) && (pv_ext < VS_END),
               (ph_ext >= HS_FIRST) && (ph_ext < HS_END),
               (pv_ext >= VB_START),
               (ph_ext >= HB_START)};
  end

  if (PIX_LAT == 1) begin : g_lat1
    assign tmg_shift = tmg_p0;
  end else begin : g_latn
    assign tmg_shift = {tmg_pn[W-5:0], tmg_p0};
  end

  // The nibble about to become the output stage also gates the pixel captured on this enable
  assign tmg_next = tmg_shift[W-1 -: 4];

  assign HBLANK = tmg_pn[W-4];
  assign VBLANK = tmg_pn[W-3];
  assign HSYNC  = tmg_pn[W-2];
  assign VSYNC  = tmg_pn[W-1];

  // Stages 1..PIX_LAT: counters, alignment shift register and pixel register all step on PCLK_EN
  always_ff @(posedge clk40M) begin
    if (!reset) begin
      PH      <= '0;
      PV      <= '0;
      tmg_pn  <= {PIX_LAT{4'b0011}};
      {B, G, R} <= '0;
      CE_PIX  <= 1'b0;
      FRAME   <= 1'b0;
    end else begin
      CE_PIX <= PCLK_EN;
      FRAME  <= PCLK_EN && ph_wrap && pv_wrap;
      if (PCLK_EN) begin
        PH     <= ph_wrap ? 9'd0 : PH + 9'd1;
        if (ph_wrap)
          PV   <= pv_wrap ? 9'd0 : PV + 9'd1;
        tmg_pn <= tmg_shift;
        if (tmg_next[0] || tmg_next[1])
          {B, G, R} <= '0;
        else
          {B, G, R} <= POUT;
      end
    end
  end

endmodule

// File: tb/tb_segasys1_vtiming.sv
// Directed bench for segasys1_vtiming at default timing parameters.
module tb_segasys1_vtiming;

  logic        clk40M = 1'b0;
  logic        reset;
  logic        PCLK_EN;
  logic [11:0] POUT;
  logic [8:0]  PH;
  logic [8:0]  PV;
  logic        CE_PIX;
  logic [3:0]  R;
  logic [3:0]  G;
  logic [3:0]  B;
  logic        HBLANK;
  logic        VBLANK;
  logic        HSYNC;
  logic        VSYNC;
  logic        FRAME;

  int n_asserts = 0;
  int n_fail    = 0;
  int frame_hits = 0;

  segasys1_vtiming dut (
    .clk40M (clk40M),
    .reset  (reset),
    .PCLK_EN(PCLK_EN),
    .POUT   (POUT),
    .PH     (PH),
    .PV     (PV),
    .CE_PIX (CE_PIX),
    .R      (R),
    .G      (G),
    .B      (B),
    .HBLANK (HBLANK),
    .VBLANK (VBLANK),
    .HSYNC  (HSYNC),
    .VSYNC  (VSYNC),
    .FRAME  (FRAME)
  );

  always #5 clk40M = ~clk40M;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clk40M cycle with the given enable; outputs are sampled 1ns after the edge.
  task automatic cyc(input logic en);
    PCLK_EN = en;
    @(posedge clk40M);
    #1;
    if (FRAME) frame_hits++;
  endtask

  task automatic run_to(input int ph, input int pv);
    int n;
    n = 0;
    while (!(PH == 9'(ph) && PV == 9'(pv)) && n < 90000) begin
      cyc(1'b1);
      n++;
    end
    check("run_to_reached", {31'd0, (PH == 9'(ph) && PV == 9'(pv))}, 32'd1);
  endtask

  initial begin
    reset   = 1'b0;
    PCLK_EN = 1'b0;
    POUT    = 12'hABC;

    // Reset held with the enable toggling
    for (int i = 0; i < 5; i++) begin
      cyc(i[0]);
      check("rst_ph", PH, 0);
      check("rst_pv", PV, 0);
      check("rst_blank", {HBLANK, VBLANK}, 2'b11);
      check("rst_sync", {HSYNC, VSYNC}, 2'b00);
      check("rst_rgb", {B, G, R}, 0);
      check("rst_ce_frame", {CE_PIX, FRAME}, 2'b00);
    end

    reset = 1'b1;
    cyc(1'b1);
    check("first_en_ph", PH, 1);
    check("first_en_pv", PV, 0);
    check("first_en_ce", CE_PIX, 1);
    check("first_en_hblank", HBLANK, 1);
    check("first_en_rgb", {B, G, R}, 0);
    cyc(1'b0);
    check("idle_ph_hold", PH, 1);
    check("idle_ce", CE_PIX, 0);
    cyc(1'b1);
    check("second_en_ph", PH, 2);
    check("second_en_hblank", HBLANK, 0);
    check("second_en_rgb", {B, G, R}, 12'hABC);

    // Enable gated off for 1000 cycles mid-line
    for (int i = 0; i < 1000; i++) begin
      cyc(1'b0);
      check("gate_ce", CE_PIX, 0);
    end
    check("gate_ph", PH, 2);
    check("gate_pv", PV, 0);
    check("gate_rgb", {B, G, R}, 12'hABC);
    check("gate_tmg", {HBLANK, VBLANK, HSYNC, VSYNC}, 4'b0000);
    cyc(1'b1);
    check("resume_ph", PH, 3);

    // Horizontal blank edge
    run_to(255, 0);
    cyc(1'b1);
    cyc(1'b1);
    check("hb_edge_257", HBLANK, 0);
    check("hb_edge_257_rgb", {B, G, R}, 12'hABC);
    cyc(1'b1);
    check("hb_edge_258", HBLANK, 1);
    check("hb_edge_258_rgb", {B, G, R}, 0);

    // Horizontal sync
    run_to(280, 0);
    check("hs_at_280", HSYNC, 0);
    cyc(1'b1);
    check("hs_at_281", HSYNC, 0);
    cyc(1'b1);
    check("hs_at_282", HSYNC, 1);
    check("hs_rgb_blank", {B, G, R}, 0);
    begin
      int n_hs;
      n_hs = 1;
      for (int i = 0; i < 100; i++) begin
        cyc(1'b1);
        if (HSYNC) n_hs++;
        else break;
      end
      check("hs_width", n_hs, 24);
    end

    // Start of line 1 and a second pixel pattern
    run_to(0, 1);
    check("line1_hblank", HBLANK, 1);
    cyc(1'b1);
    check("line1_ph1_hblank", HBLANK, 1);
    cyc(1'b1);
    check("line1_ph2_hblank", HBLANK, 0);
    check("line1_rgb", {B, G, R}, 12'hABC);
    POUT = 12'h5A3;
    cyc(1'b1);
    check("pattern_r", R, 4'h3);
    check("pattern_g", G, 4'hA);
    check("pattern_b", B, 4'h5);

    // Vertical blank and sync
    run_to(1, 224);
    check("vb_before", VBLANK, 0);
    cyc(1'b1);
    check("vb_after", VBLANK, 1);
    check("vb_rgb", {B, G, R}, 0);
    run_to(1, 240);
    check("vs_before", VSYNC, 0);
    cyc(1'b1);
    check("vs_rise", VSYNC, 1);
    run_to(1, 243);
    check("vs_last", VSYNC, 1);
    cyc(1'b1);
    check("vs_fall", VSYNC, 0);

    // Frame wrap
    run_to(319, 261);
    check("no_early_frame", frame_hits, 0);
    cyc(1'b1);
    check("wrap_ph", PH, 0);
    check("wrap_pv", PV, 0);
    check("wrap_frame", FRAME, 1);
    cyc(1'b1);
    check("frame_one_cycle", FRAME, 0);
    check("after_wrap_ph", PH, 1);

    // Reset mid-frame
    run_to(50, 2);
    reset = 1'b0;
    cyc(1'b1);
    check("midrst_ph", PH, 0);
    check("midrst_pv", PV, 0);
    check("midrst_blank", {HBLANK, VBLANK}, 2'b11);
    check("midrst_rgb", {B, G, R}, 0);
    check("midrst_frame", FRAME, 0);
    reset = 1'b1;
    cyc(1'b0);
    check("midrst_hold_ph", PH, 0);
    check("midrst_hold_frame", FRAME, 0);
    cyc(1'b1);
    check("midrst_restart_ph", PH, 1);
    check("midrst_restart_pv", PV, 0);
    check("midrst_restart_frame", FRAME, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
